mips_multicycle_ctrl: RTL and testbench
=======================================

MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 Parameters SHALL be none; all encodings SHALL come from the shared package.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Op  input  6  instruction opcode, IR[31:26].
REQ-005 Funct  input  6  R-type function field, IR[5:0].
REQ-006 Zero  input  1  ALU zero flag from the datapath ALU.
REQ-007 Outputs SHALL be 1-bit unless noted:
- IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA.
- ALUSrcB (2 bits), PCSrc (2 bits), ALUControl (3 bits), PCEn.
- State (4 bits), exported for debug.

Function
REQ-008 The block SHALL be a Moore FSM plus a combinational ALU-control decode.
REQ-009 FSM states, encoded 0-11: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
REQ-010 FETCH SHALL drive IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00, IRWrite=1, PCWrite=1; next state DECODE.
REQ-011 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target), then branch on Op:
- lw 100011 or sw 101011 -> MEMADR.
- 000000 -> RTYPEEX.
- beq 000100 -> BEQEX.
- addi 001000 -> ADDIEX.
- j 000010 -> JEX.
- any other Op -> FETCH.
REQ-012 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=add; next MEMRD for lw, MEMWR for sw.
REQ-013 MEMRD SHALL drive IorD=1; next MEMWB.
REQ-014 MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-015 MEMWR SHALL drive IorD=1, MemWrite=1; next FETCH.
REQ-016 RTYPEEX SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=funct; next RTYPEWB.
REQ-017 RTYPEWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1; next FETCH.
REQ-018 BEQEX SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSrc=01, Branch=1; next FETCH.
REQ-019 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=add; next ADDIWB.
REQ-020 ADDIWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1; next FETCH.
REQ-021 JEX SHALL drive PCSrc=10, PCWrite=1; next FETCH.
REQ-022 Any output not listed for a state SHALL be 0; no X SHALL appear on any output.
REQ-023 PCEn SHALL equal PCWrite OR (Branch AND Zero), combinationally in the same cycle.
REQ-024 ALUControl mapping:
- ALUOp=add -> 010; ALUOp=sub -> 110.
- ALUOp=funct -> Funct 100000=010, 100010=110, 100100=000, 100101=001, 101010=111.
- Unlisted Funct SHALL give 010.
REQ-025 Cycle counts SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown Op 2.
REQ-026 State encoding 4'd12-4'd15 SHALL transition to FETCH with all outputs 0.

Reset
REQ-027 Asserting reset SHALL force State=FETCH immediately, regardless of clk.
REQ-028 While reset is high, outputs SHALL show FETCH values (IRWrite=1, PCEn=1, ALUControl=010).
REQ-029 Reset asserted mid-instruction SHALL abandon that instruction; the first rising edge after deassertion SHALL move FETCH->DECODE.

Structure
REQ-030 Package mips_ctrl_pkg SHALL hold:
- the state enum;
- opcode and funct localparams;
- the ALUOp enum (add/sub/funct);
- the ALUControl encodings 000/001/010/011/110/111 shared with the ALU.
REQ-031 ALU-control decode SHALL be a separate combinational sub-module mips_alu_decoder(ALUOp, Funct -> ALUControl); the FSM and output decode SHALL live in mips_multicycle_ctrl.

Verification
REQ-032 Reset pulse mid-MEMRD -> State=FETCH asynchronously; after release, DECODE at the next edge.
REQ-033 Op=100011 from FETCH -> states 0,1,2,3,4,0; MEMWB has RegWrite=1 and MemtoReg=1.
REQ-034 Op=000000, Funct=101010 -> RTYPEEX has ALUControl=111; RTYPEWB has RegDst=1; 4 cycles total.
REQ-035 Op=000100 in BEQEX -> Zero=1 gives PCEn=1, PCSrc=01; Zero=0 gives PCEn=0.
REQ-036 Op=000010 -> JEX has PCEn=1, PCSrc=10; Op=111111 -> DECODE then FETCH, with RegWrite and MemWrite never asserted.
REQ-037 Sweep all 64 Funct values in RTYPEEX -> the 5 listed values map per REQ-024; all others give 010.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared encodings for the multicycle MIPS controller and its ALU:
// FSM state enum, opcode/funct constants, the ALUOp enum and the
// ALUControl codes the datapath ALU understands.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALUC_AND  = 3'b000;
    localparam logic [2:0] ALUC_OR   = 3'b001;
    localparam logic [2:0] ALUC_ADD  = 3'b010;
    localparam logic [2:0] ALUC_RSV3 = 3'b011;
    localparam logic [2:0] ALUC_SUB  = 3'b110;
    localparam logic [2:0] ALUC_SLT  = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder
// Combinational ALU-control decode.
//   ALUOp      in  : add / sub / funct request from the FSM
//   Funct      in  : R-type function field IR[5:0]
//   ALUControl out : 3-bit ALU operation code
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t      ALUOp,
    input  logic [5:0]  Funct,
    output logic [2:0]  ALUControl
);

    // Map the FSM request (and for R-type the funct field) to an ALU code;
    // unknown funct values fall back to add so the ALU never sees junk.
    always_comb begin
        ALUControl = ALUC_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALUC_ADD;
            ALUOP_SUB: ALUControl = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FN_ADD:  ALUControl = ALUC_ADD;
                    FN_SUB:  ALUControl = ALUC_SUB;
                    FN_AND:  ALUControl = ALUC_AND;
                    FN_OR:   ALUControl = ALUC_OR;
                    FN_SLT:  ALUControl = ALUC_SLT;
                    default: ALUControl = ALUC_ADD;
                endcase
            end
            default: ALUControl = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Moore FSM controller for a multicycle MIPS datapath (lw, sw, R-type,
// beq, addi, j) plus the ALU-control decode.
//   clk, reset (async, active-high)
//   Op, Funct   : instruction fields; Zero : ALU zero flag
//   IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], PCSrc[1:0], ALUControl[2:0], PCEn : datapath controls
//   State[3:0]  : current FSM state, for debug
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic [2:0]  ALUControl,
    output logic        PCEn,
    output logic [3:0]  State
);

    state_t      state_q;
    state_t      state_d;
    aluop_t      aluop_s;
    logic        branch_s;
    logic        pcwrite_s;
    logic        illegal_s;
    logic [2:0]  dec_aluc_s;

    // State register; reset forces FETCH without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; every output defaults to 0.
    always_comb begin
        state_d   = S_FETCH;
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        PCSrc     = 2'b00;
        aluop_s   = ALUOP_ADD;
        branch_s  = 1'b0;
        pcwrite_s = 1'b0;
        illegal_s = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b01;
                IRWrite   = 1'b1;
                pcwrite_s = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                ALUSrcB = 2'b11;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (Op == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_RTYPEEX: begin
                ALUSrcA = 1'b1;
                aluop_s = ALUOP_FUNCT;
                state_d = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQEX: begin
                ALUSrcA  = 1'b1;
                aluop_s  = ALUOP_SUB;
                PCSrc    = 2'b01;
                branch_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JEX: begin
                PCSrc     = 2'b10;
                pcwrite_s = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                // Encodings 12-15: recover to FETCH with everything quiet
                illegal_s = 1'b1;
                state_d   = S_FETCH;
            end
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .ALUOp      (aluop_s),
        .Funct      (Funct),
        .ALUControl (dec_aluc_s)
    );

    // Illegal states also silence ALUControl, which otherwise idles at add.
    assign ALUControl = illegal_s ? 3'b000 : dec_aluc_s;
    assign PCEn       = pcwrite_s | (branch_s & Zero);
    assign State      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUControl;
    logic        PCEn;
    logic [3:0]  State;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;
    int exp_state = 0;
    int cycles;

    logic [2:0] snap_alu [16];
    logic       snap_pcen [16];
    logic [1:0] snap_pcsrc [16];
    logic       snap_regdst [16];
    logic       snap_regwrite [16];
    logic       snap_memtoreg [16];
    logic       snap_memwrite [16];

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl),
        .PCEn(PCEn), .State(State)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference ALU code for an R-type funct field
    function automatic logic [2:0] alu_ref(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Number of cycles an instruction occupies
    function automatic int path_len(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            default:   return 2;
        endcase
    endfunction

    // i-th state number visited by an instruction
    function automatic int path_state(input logic [5:0] op, input int i);
        if (i == 0) return 0;
        if (i == 1) return 1;
        case (op)
            6'b100011: return (i == 2) ? 2 : ((i == 3) ? 3 : 4);
            6'b101011: return (i == 2) ? 2 : 5;
            6'b000000: return (i == 2) ? 6 : 7;
            6'b001000: return (i == 2) ? 9 : 10;
            6'b000100: return 8;
            6'b000010: return 11;
            default:   return 0;
        endcase
    endfunction

    // Per-cycle comparison of every output against the state table
    always @(negedge clk) begin
        int s;
        if (chk_en) begin
            s = exp_state;
            chk("State", State, s);
            chk("IorD", IorD, (s == 3 || s == 5));
            chk("MemWrite", MemWrite, (s == 5));
            chk("IRWrite", IRWrite, (s == 0));
            chk("RegDst", RegDst, (s == 7));
            chk("MemtoReg", MemtoReg, (s == 4));
            chk("RegWrite", RegWrite, (s == 4 || s == 7 || s == 10));
            chk("ALUSrcA", ALUSrcA, (s == 2 || s == 6 || s == 8 || s == 9));
            chk("ALUSrcB", ALUSrcB, (s == 0) ? 1 : (s == 1) ? 3 : (s == 2 || s == 9) ? 2 : 0);
            chk("PCSrc", PCSrc, (s == 8) ? 1 : (s == 11) ? 2 : 0);
            chk("PCEn", PCEn, (s == 0 || s == 11 || (s == 8 && Zero == 1'b1)));
            if (s == 0 || s == 1 || s == 2 || s == 9) chk("ALUControl_add", ALUControl, 3'b010);
            if (s == 8) chk("ALUControl_sub", ALUControl, 3'b110);
            if (s == 6) chk("ALUControl_funct", ALUControl, alu_ref(Funct));
        end
    end

    // Run one instruction from FETCH; zmode 0=random Zero, 1=Zero 0, 2=Zero 1
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
        int n;
        int s;
        Op = op;
        Funct = fn;
        n = path_len(op);
        cycles = -1;
        for (int i = 0; i < n; i++) begin
            s = path_state(op, i);
            exp_state = s;
            chk_en = 1'b1;
            Zero = (zmode == 0) ? 1'($urandom_range(0, 1)) : ((zmode == 2) ? 1'b1 : 1'b0);
            @(negedge clk);
            #1;
            snap_alu[s] = ALUControl;
            snap_pcen[s] = PCEn;
            snap_pcsrc[s] = PCSrc;
            snap_regdst[s] = RegDst;
            snap_regwrite[s] = RegWrite;
            snap_memtoreg[s] = MemtoReg;
            snap_memwrite[s] = MemWrite;
            @(posedge clk);
            #2;
            if (cycles < 0 && State == 4'd0) cycles = i + 1;
        end
        if (cycles < 0) cycles = 99;
    endtask

    logic [5:0] pin_f [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] pin_a [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rop;
        reset = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
        exp_state = 0;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_state", State, 4'd0);
        chk("rst_irwrite", IRWrite, 1'b1);
        chk("rst_pcen", PCEn, 1'b1);
        chk("rst_aluctl", ALUControl, 3'b010);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // lw
        run_instr(6'b100011, 6'h15, 0);
        chk("lw_cycles", cycles, 5);
        chk("lw_memwb_regwrite", snap_regwrite[4], 1'b1);
        chk("lw_memwb_memtoreg", snap_memtoreg[4], 1'b1);
        // sw, addi
        run_instr(6'b101011, 6'h00, 0);
        chk("sw_cycles", cycles, 4);
        chk("sw_memwr_memwrite", snap_memwrite[5], 1'b1);
        run_instr(6'b001000, 6'h2a, 0);
        chk("addi_cycles", cycles, 4);
        // slt
        run_instr(6'b000000, 6'b101010, 0);
        chk("slt_aluctl", snap_alu[6], 3'b111);
        chk("slt_regdst", snap_regdst[7], 1'b1);
        chk("rtype_cycles", cycles, 4);
        // beq taken / not taken
        run_instr(6'b000100, 6'h00, 2);
        chk("beq_z1_pcen", snap_pcen[8], 1'b1);
        chk("beq_z1_pcsrc", snap_pcsrc[8], 2'b01);
        chk("beq_cycles", cycles, 3);
        run_instr(6'b000100, 6'h00, 1);
        chk("beq_z0_pcen", snap_pcen[8], 1'b0);
        // j and unknown opcode
        run_instr(6'b000010, 6'h00, 0);
        chk("j_pcen", snap_pcen[11], 1'b1);
        chk("j_pcsrc", snap_pcsrc[11], 2'b10);
        chk("j_cycles", cycles, 3);
        run_instr(6'b111111, 6'h00, 0);
        chk("unk_cycles", cycles, 2);
        chk("unk_regwrite", snap_regwrite[1], 1'b0);
        chk("unk_memwrite", snap_memwrite[1], 1'b0);

        // Funct sweep in RTYPEEX
        for (int f = 0; f < 64; f++) run_instr(6'b000000, 6'(f), 0);
        for (int k = 0; k < 5; k++) begin
            run_instr(6'b000000, pin_f[k], 0);
            chk("funct_pin", snap_alu[6], pin_a[k]);
        end
        run_instr(6'b000000, 6'b111111, 0);
        chk("funct_unlisted", snap_alu[6], 3'b010);

        // Reset mid-MEMRD
        Op = 6'b100011;
        for (int i = 0; i < 3; i++) begin
            exp_state = path_state(6'b100011, i);
            @(negedge clk);
            @(posedge clk);
            #2;
        end
        exp_state = 3;
        @(negedge clk);
        #1;
        chk("pre_rst_memrd", State, 4'd3);
        reset = 1'b1;
        #1;
        chk("async_rst_state", State, 4'd0);
        chk("async_rst_irwrite", IRWrite, 1'b1);
        exp_state = 0;
        @(posedge clk);
        #2;
        chk("rst_hold_state", State, 4'd0);
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("post_rst_decode", State, 4'd1);
        Op = 6'b111111;
        exp_state = 1;
        @(negedge clk);
        @(posedge clk);
        #2;

        // Random instruction stream
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 6))
                0: rop = 6'b100011;
                1: rop = 6'b101011;
                2: rop = 6'b000000;
                3: rop = 6'b000100;
                4: rop = 6'b001000;
                5: rop = 6'b000010;
                default: rop = 6'($urandom_range(0, 63));
            endcase
            run_instr(rop, 6'($urandom_range(0, 63)), 0);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
